connect_ser_des: RTL and testbench
==================================

CONNECT_SER_DES -- requirements
Module: connect_ser_des

Interface
REQ-001 Parameter: DATA_W, default 8, width of the parallel input word, the output word and the serial payload.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: nreset  input  1  asynchronous, active-low reset.
REQ-004 Port: in_comp  input  DATA_W  parallel word to transmit.
REQ-005 Port: out_comp  output  DATA_W  last word received correctly over the internal serial link.
REQ-006 The block SHALL have one clock; reset SHALL be asynchronous and active-low, named clk and nreset.

Function
REQ-007 The block SHALL contain a serializer and a deserializer joined by one internal 1-bit line (ser_line); ser_line SHALL be registered in the serializer.
REQ-008 Frame format SHALL be FRAME_LEN = DATA_W+2 cycles: start bit 0, then DATA_W data bits MSB first, then stop bit 1; the idle level SHALL be 1.
REQ-009 Serializer states SHALL be IDLE, START, DATA, STOP.
REQ-010 In IDLE, the serializer SHALL load in_comp into its shift register and go to START on the next rising edge.
REQ-011 From START it SHALL go to DATA; after DATA_W data cycles it SHALL go to STOP; after STOP it SHALL load in_comp again and go to START, so frames run back to back with no idle gap.
REQ-012 Changes on in_comp between load edges SHALL be ignored; only the value present at the load edge is sent.
REQ-013 Deserializer states SHALL be IDLE, DATA, STOP; in IDLE, a sampled 0 on ser_line SHALL count as a start bit and move it to DATA.
REQ-014 In DATA, the deserializer SHALL shift in DATA_W bits MSB first, one per edge, then go to STOP.
REQ-015 In STOP, a sampled 1 SHALL update out_comp with the assembled word on that same edge.
REQ-016 In STOP, a sampled 0 (framing error) SHALL leave out_comp unchanged and discard the word; the deserializer then returns to IDLE in both cases.
REQ-017 Zero-valued data bits SHALL never be taken as start bits, because start detection happens only in IDLE.
REQ-018 Latency: if in_comp is loaded at edge E0, out_comp SHALL show that value right after edge E0+FRAME_LEN (10 edges for DATA_W=8).
REQ-019 Throughput SHALL be one word per FRAME_LEN cycles.
REQ-020 out_comp SHALL be driven from a register and SHALL change only on the stop-bit edge.
REQ-021 Bit counters SHALL be $clog2(DATA_W+1) bits wide and SHALL reset to 0 at each frame start.

Reset
REQ-022 While nreset = 0, all of the following SHALL hold at once, regardless of clk: out_comp = 0, ser_line = 1, both state machines in IDLE, shift registers and counters = 0.
REQ-023 Reset in the middle of a frame SHALL drop the partial frame; out_comp SHALL stay 0 until a complete new frame arrives.
REQ-024 The first load after reset SHALL happen on the first rising edge of clk with nreset = 1.

Structure
REQ-025 A shared package connect_ser_des_pkg SHALL hold: DATA_W default, FRAME_LEN, the START/STOP/IDLE line levels, and the serializer and deserializer state enumerations.
REQ-026 The serializer (ser_tx) and the deserializer (des_rx) SHALL be separate sub-modules.
REQ-027 connect_ser_des SHALL only instantiate ser_tx and des_rx and wire them through ser_line.

Verification
REQ-028 Reset: hold nreset = 0 for 3 cycles with in_comp = 8'h3C -> out_comp = 8'h00 and ser_line = 1 throughout.
REQ-029 Single word: release reset with in_comp = 8'hA5 held -> out_comp = 8'hA5 exactly 10 edges after the load edge, and ser_line carries 0,1,0,1,0,0,1,0,1,1.
REQ-030 Stream: apply 8'h00, 8'hFF, 8'h81 at successive load edges -> out_comp shows 00, FF, 81 at 10-cycle intervals, with no missed or extra updates.
REQ-031 Mid-frame change: in_comp = 8'h12, changed to 8'h34 three cycles after the load edge -> the frame delivers 8'h12, and the next frame delivers 8'h34.
REQ-032 Reset mid-frame: assert nreset five cycles into an 8'h77 frame -> out_comp = 0 at once, and 8'h77 appears 10 edges after the first post-reset load.
REQ-033 Framing error: force ser_line to 0 during one stop bit -> out_comp holds its previous value, and the next frame is received correctly.

Source files
------------

// File: rtl/connect_ser_des_pkg.sv
// Shared definitions for the connect_ser_des serial link.
// Holds the default word width, the frame length, the line levels used on
// the internal serial wire and the state encodings of both link ends.
package connect_ser_des_pkg;

  // Default parallel word width and resulting frame length (start + data + stop).
  localparam int DATA_W_DEF = 8;
  localparam int FRAME_LEN  = DATA_W_DEF + 2;

  // Serial line levels.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Serializer states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Deserializer states.
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  // Frame length for an arbitrary payload width.
  function automatic int frame_len(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/connect_ser_des_des_rx.sv
// Deserializer: detects a start bit while idle, shifts in DATA_W bits MSB
// first and publishes the word only when a valid stop bit follows.
// Ports:
//   i_clk       system clock, rising edge
//   i_nreset    asynchronous active-low reset
//   i_ser_line  serial line from the serializer
//   o_data      last correctly framed word (registered)
module des_rx
  import connect_ser_des_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_nreset,
  input  logic              i_ser_line,
  output logic [DATA_W-1:0] o_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_e         r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out;

  // Receive sequencer; start bits are only recognised in IDLE, so zero data bits never restart a frame.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= RX_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (i_ser_line == LINE_START) begin
            r_cnt   <= '0;
            r_state <= RX_DATA;
          end else begin
            r_state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          r_shreg <= {r_shreg[DATA_W-2:0], i_ser_line};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= RX_STOP;
          end else begin
            r_state <= RX_DATA;
          end
        end
        // A missing stop bit discards the word; either way go back to hunting.
        RX_STOP: begin
          if (i_ser_line == LINE_STOP) begin
            r_out <= r_shreg;
          end else begin
            r_out <= r_out;
          end
          r_state <= RX_IDLE;
        end
        default: begin
          r_state <= RX_IDLE;
          r_shreg <= '0;
          r_cnt   <= '0;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/connect_ser_des_ser_tx.sv
// Serializer: loads a parallel word and sends it as start bit, DATA_W data
// bits MSB first, stop bit, with frames running back to back.
// Ports:
//   i_clk       system clock, rising edge
//   i_nreset    asynchronous active-low reset
//   i_data      parallel word, sampled only at the load edge
//   o_ser_line  registered serial line (idle level 1)
module ser_tx
  import connect_ser_des_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_nreset,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ser_line
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ser_line;

  // Frame sequencer: the line register always holds the level of the current state.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state    <= TX_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_ser_line <= LINE_IDLE;
    end else begin
      case (r_state)
        // Leaving IDLE or STOP is the load edge: capture the word, drive start bit.
        TX_IDLE, TX_STOP: begin
          r_shreg    <= i_data;
          r_cnt      <= '0;
          r_ser_line <= LINE_START;
          r_state    <= TX_START;
        end
        TX_START: begin
          r_ser_line <= r_shreg[DATA_W-1];
          r_shreg    <= {r_shreg[DATA_W-2:0], 1'b0};
          r_cnt      <= CNT_W'(1);
          r_state    <= TX_DATA;
        end
        // r_cnt counts data bits already placed on the line.
        TX_DATA: begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            r_ser_line <= LINE_STOP;
            r_state    <= TX_STOP;
          end else begin
            r_ser_line <= r_shreg[DATA_W-1];
            r_shreg    <= {r_shreg[DATA_W-2:0], 1'b0};
            r_cnt      <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= TX_IDLE;
          r_shreg    <= '0;
          r_cnt      <= '0;
          r_ser_line <= LINE_IDLE;
        end
      endcase
    end
  end

  assign o_ser_line = r_ser_line;

endmodule

// File: rtl/connect_ser_des.sv
// Top: a serializer and a deserializer joined by one internal serial wire.
// Ports:
//   clk       system clock, rising edge
//   nreset    asynchronous active-low reset
//   in_comp   parallel word to transmit
//   out_comp  last word received correctly over the internal link
module connect_ser_des
  import connect_ser_des_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [DATA_W-1:0] in_comp,
  output logic [DATA_W-1:0] out_comp
);

  logic ser_line;

  ser_tx #(.DATA_W(DATA_W)) u_ser_tx (
    .i_clk      (clk),
    .i_nreset   (nreset),
    .i_data     (in_comp),
    .o_ser_line (ser_line)
  );

  des_rx #(.DATA_W(DATA_W)) u_des_rx (
    .i_clk      (clk),
    .i_nreset   (nreset),
    .i_ser_line (ser_line),
    .o_data     (out_comp)
  );

endmodule

// File: tb/tb_connect_ser_des.sv
module tb_connect_ser_des;
  import connect_ser_des_pkg::*;

  typedef struct packed {
    int         due;
    logic [7:0] val;
  } ent_t;

  logic       clk;
  logic       nreset;
  logic [7:0] in_comp;
  logic [7:0] out_comp;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_load = 0;
  int   drop_due = -1;
  bit   load_en = 1'b0;
  bit   mon_en = 1'b0;
  logic [7:0] exp_out = 8'h00;
  ent_t sb[$];

  connect_ser_des #(.DATA_W(8)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .in_comp  (in_comp),
    .out_comp (out_comp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Wait until the falling edge that follows rising edge number x.
  task automatic wait_edge(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  // Edge counter and scoreboard push: every load edge queues the word due FRAME_LEN edges later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!load_en) begin
      next_load <= cyc + 2;
    end else if (cyc + 1 == next_load) begin
      sb.push_back('{cyc + 1 + FRAME_LEN, in_comp});
      next_load <= next_load + FRAME_LEN;
    end
  end

  // Monitor: pop due entries and require out_comp to hold the expected word every cycle.
  always @(negedge clk) begin
    #1;
    if (!nreset) begin
      sb.delete();
      exp_out = 8'h00;
    end else if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ent_t e;
        e = sb.pop_front();
        if (e.due != drop_due) exp_out = e.val;
      end
      chk("mon_out", out_comp, exp_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int l2;
    logic [9:0] a5_bits;
    nreset  = 1'b0;
    in_comp = 8'h3C;
    a5_bits = 10'b0101001011;

    repeat (3) begin
      @(negedge clk);
      chk("rst_out", out_comp, 8'h00);
      chk("rst_line", {7'd0, dut.ser_line}, 8'h01);
    end

    nreset  = 1'b1;
    in_comp = 8'hA5;
    load_en = 1'b1;
    mon_en  = 1'b1;
    l0 = cyc + 1;

    for (int k = 0; k < 10; k++) begin
      wait_edge(l0 + k);
      chk("a5_line", {7'd0, dut.ser_line}, {7'd0, a5_bits[9-k]});
    end
    chk("a5_early", out_comp, 8'h00);
    wait_edge(l0 + 10);
    chk("a5_latency", out_comp, 8'hA5);

    wait_edge(l0 + 19); in_comp = 8'h00;
    wait_edge(l0 + 29); in_comp = 8'hFF;
    wait_edge(l0 + 30); chk("stream_00", out_comp, 8'h00);
    wait_edge(l0 + 39); in_comp = 8'h81;
    wait_edge(l0 + 40); chk("stream_ff", out_comp, 8'hFF);
    wait_edge(l0 + 49); in_comp = 8'h12;
    wait_edge(l0 + 50); chk("stream_81", out_comp, 8'h81);
    wait_edge(l0 + 53); in_comp = 8'h34;
    wait_edge(l0 + 60); chk("midchg_12", out_comp, 8'h12);
    wait_edge(l0 + 69); in_comp = 8'h5A;
    wait_edge(l0 + 70); chk("midchg_34", out_comp, 8'h34);
    wait_edge(l0 + 79); in_comp = 8'hC3;
    wait_edge(l0 + 80); chk("pre_ferr", out_comp, 8'h5A);

    wait_edge(l0 + 89);
    drop_due = l0 + 90;
    force dut.ser_line = 1'b0;
    wait_edge(l0 + 90);
    chk("ferr_hold", out_comp, 8'h5A);
    release dut.ser_line;
    wait_edge(l0 + 99); in_comp = 8'h77;
    wait_edge(l0 + 100); chk("ferr_recover", out_comp, 8'hC3);

    wait_edge(l0 + 105);
    nreset  = 1'b0;
    load_en = 1'b0;
    #1;
    chk("rstmid_out", out_comp, 8'h00);
    chk("rstmid_line", {7'd0, dut.ser_line}, 8'h01);
    wait_edge(l0 + 107);
    chk("rstmid_hold", out_comp, 8'h00);
    nreset  = 1'b1;
    load_en = 1'b1;
    l2 = l0 + 108;
    wait_edge(l2 + 9);
    chk("rstmid_early", out_comp, 8'h00);
    wait_edge(l2 + 10);
    chk("rstmid_77", out_comp, 8'h77);
    wait_edge(l2 + 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
